// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: parametrised 3-stage floating-point adder/subtractor.
// Round-to-nearest-even, denormals flushed to zero, valid/ready stall.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  input  logic                 sub_i,
  input  logic                 vld_i,
  output logic                 rdy_o,
  output logic [EXP_W+MAN_W:0] answer_o,
  output logic [1:0]           num_status_o,
  output logic                 vld_o,
  input  logic                 rdy_i
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int FW = MAN_W + 4;
  localparam int SW = FW + 1;
  localparam int PW = $clog2(SW);
  localparam int LW = (EXP_W > PW) ? EXP_W : PW;
  localparam int XW = LW + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic signed [XW-1:0] EMAX_X = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0] E_ONE = XW'(1);
  localparam logic [1:0] ST_NORM = 2'b00;
  localparam logic [1:0] ST_ZERO = 2'b01;
  localparam logic [1:0] ST_INF  = 2'b10;
  localparam logic [1:0] ST_NAN  = 2'b11;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en    = !(vld_o && !rdy_i);
  assign rdy_o = en;

  logic             sa, sb, swap;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic             zero_a, zero_b;
  logic [EXP_W-1:0] ea, eb, e_big, d;
  logic [MAN_W:0]   ma, mb, m_big, m_sml;
  logic [2*FW-1:0]  wide;
  logic [FW-1:0]    aligned;
  int               sh;

  always_comb begin
    sa      = a_i[W-1];
    sb      = b_i[W-1] ^ sub_i;
    ea      = a_i[W-2:MAN_W];
    eb      = b_i[W-2:MAN_W];
    nan_a   = (ea == EMAX) && (a_i[MAN_W-1:0] != '0);
    nan_b   = (eb == EMAX) && (b_i[MAN_W-1:0] != '0);
    inf_a   = (ea == EMAX) && (a_i[MAN_W-1:0] == '0);
    inf_b   = (eb == EMAX) && (b_i[MAN_W-1:0] == '0);
    zero_a  = (ea == '0);
    zero_b  = (eb == '0);
    ma      = zero_a ? '0 : {1'b1, a_i[MAN_W-1:0]};
    mb      = zero_b ? '0 : {1'b1, b_i[MAN_W-1:0]};
    swap    = {eb, mb} > {ea, ma};
    e_big   = swap ? eb : ea;
    m_big   = swap ? mb : ma;
    m_sml   = swap ? ma : mb;
    d       = swap ? (eb - ea) : (ea - eb);
    // low half of the wide shift catches every bit lost to sticky
    sh      = (int'(d) > FW) ? FW : int'(d);
    wide    = {m_sml, 3'b000, {FW{1'b0}}} >> sh;
    aligned = {wide[2*FW-1:FW+1], wide[FW] | (|wide[FW-1:0])};
  end

  logic             s1_vld, s1_nan, s1_inf, s1_isg;
  logic             s1_zng, s1_sgn, s1_sub;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W:0]   s1_mbig;
  logic [FW-1:0]    s1_msml;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_nan  <= 1'b0;
      s1_inf  <= 1'b0;
      s1_isg  <= 1'b0;
      s1_zng  <= 1'b0;
      s1_sgn  <= 1'b0;
      s1_sub  <= 1'b0;
      s1_exp  <= '0;
      s1_mbig <= '0;
      s1_msml <= '0;
    end else if (en) begin
      s1_vld  <= vld_i;
      s1_nan  <= nan_a || nan_b || (inf_a && inf_b && (sa != sb));
      s1_inf  <= inf_a || inf_b;
      s1_isg  <= inf_a ? sa : sb;
      s1_zng  <= zero_a && zero_b && sa && sb;
      s1_sgn  <= swap ? sb : sa;
      s1_sub  <= sa != sb;
      s1_exp  <= e_big;
      s1_mbig <= m_big;
      s1_msml <= aligned;
    end
  end

  logic [SW-1:0] sum;

  always_comb begin
    if (s1_sub)
      sum = {1'b0, s1_mbig, 3'b000} - {1'b0, s1_msml};
    else
      sum = {1'b0, s1_mbig, 3'b000} + {1'b0, s1_msml};
  end

  logic             s2_vld, s2_nan, s2_inf, s2_isg;
  logic             s2_zng, s2_sgn;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_vld <= 1'b0;
      s2_nan <= 1'b0;
      s2_inf <= 1'b0;
      s2_isg <= 1'b0;
      s2_zng <= 1'b0;
      s2_sgn <= 1'b0;
      s2_exp <= '0;
      s2_sum <= '0;
    end else if (en) begin
      s2_vld <= s1_vld;
      s2_nan <= s1_nan;
      s2_inf <= s1_inf;
      s2_isg <= s1_isg;
      s2_zng <= s1_zng;
      s2_sgn <= s1_sgn;
      s2_exp <= s1_exp;
      s2_sum <= sum;
    end
  end

  logic [PW-1:0]         pos, lz;
  logic [FW-1:0]         norm;
  logic signed [XW-1:0]  e_n, e_r;
  logic                  up;
  logic [MAN_W+1:0]      mr;
  logic [MAN_W-1:0]      man_out;
  logic [W-1:0]          res;
  logic [1:0]            st;

  always_comb begin
    pos = '0;
    for (int i = 0; i < SW; i++)
      if (s2_sum[i]) pos = PW'(i);
    lz = PW'(FW - 1) - pos;
    if (s2_sum[SW-1]) begin
      norm = {s2_sum[SW-1:2], |s2_sum[1:0]};
      e_n  = XW'(s2_exp) + E_ONE;
    end else begin
      norm = s2_sum[FW-1:0] << lz;
      e_n  = XW'(s2_exp) - XW'(lz);
    end
    up      = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr      = {1'b0, norm[FW-1:3]} + (MAN_W+2)'(up);
    e_r     = e_n;
    man_out = mr[MAN_W-1:0];
    if (mr[MAN_W+1]) begin
      e_r     = e_n + E_ONE;
      man_out = mr[MAN_W:1];
    end
    res = {s2_sgn, e_r[EXP_W-1:0], man_out};
    st  = ST_NORM;
    if (s2_nan) begin
      res = QNAN;
      st  = ST_NAN;
    end else if (s2_inf) begin
      res = {s2_isg, EMAX, {MAN_W{1'b0}}};
      st  = ST_INF;
    end else if (s2_sum == '0) begin
      res = {s2_zng, {(W-1){1'b0}}};
      st  = ST_ZERO;
    end else if (e_r >= EMAX_X) begin
      res = {s2_sgn, EMAX, {MAN_W{1'b0}}};
      st  = ST_INF;
    end else if (e_r < E_ONE) begin
      res = {s2_sgn, {(W-1){1'b0}}};
      st  = ST_ZERO;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_o        <= 1'b0;
      answer_o     <= '0;
      num_status_o <= ST_ZERO;
    end else if (en) begin
      vld_o <= s2_vld;
      if (s2_vld) begin
        answer_o     <= res;
        num_status_o <= st;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: random + directed check of fp_addsub_pipe
// against an exact-arithmetic reference model (fp32 and fp16).
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, ans;
  logic        sub, vld, rdy, vo, rin;
  logic [1:0]  st;
  logic [15:0] ha, hb, hans;
  logic        hsub, hvld, hrdy, hvo, hrin;
  logic [1:0]  hst;

  int nvec = 0;
  int nerr = 0;
  logic auto_exp = 1'b0;
  logic hauto = 1'b0;
  logic [65:0] q32[$];
  logic [65:0] qh[$];

  always #5 clk = ~clk;

  fp_addsub_pipe dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .sub_i(sub),
    .vld_i(vld), .rdy_o(rdy), .answer_o(ans), .num_status_o(st),
    .vld_o(vo), .rdy_i(rin)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) duth (
    .clk_i(clk), .rst_i(rst), .a_i(ha), .b_i(hb), .sub_i(hsub),
    .vld_i(hvld), .rdy_o(hrdy), .answer_o(hans), .num_status_o(hst),
    .vld_o(hvo), .rdy_i(hrin)
  );

  task automatic chk(input string tag, input logic [65:0] got,
                     input logic [65:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(int ew, int mw, logic s,
                                       logic [63:0] e, logic [63:0] f);
    return (64'(s) << (ew + mw)) | (e << mw) | f;
  endfunction

  // exact value of a+/-b as an integer scaled by 2^(emin-bias-mw),
  // then rounded to nearest-even at mw+1 significant bits
  function automatic logic [65:0] model(int ew, int mw, logic [63:0] av,
                                        logic [63:0] bv, logic sv);
    logic [63:0]  emx, mmask, fa, fb;
    logic [319:0] xa, xb, mag, q, rem, half;
    int ea, eb, ka, kb, emin, p, sh, e;
    logic sa, sb, sg;
    emx   = (64'd1 << ew) - 64'd1;
    mmask = (64'd1 << mw) - 64'd1;
    sa = av[ew+mw];
    sb = bv[ew+mw] ^ sv;
    ea = int'((av >> mw) & emx);
    eb = int'((bv >> mw) & emx);
    fa = av & mmask;
    fb = bv & mmask;
    if ((ea == int'(emx) && fa != 0) || (eb == int'(emx) && fb != 0) ||
        (ea == int'(emx) && eb == int'(emx) && sa != sb))
      return {2'b11, pack(ew, mw, 1'b0, emx, 64'd1 << (mw - 1))};
    if (ea == int'(emx)) return {2'b10, pack(ew, mw, sa, emx, 64'd0)};
    if (eb == int'(emx)) return {2'b10, pack(ew, mw, sb, emx, 64'd0)};
    if (ea == 0 && eb == 0)
      return {2'b01, pack(ew, mw, sa & sb, 64'd0, 64'd0)};
    ka = (ea == 0) ? 1 : ea;
    kb = (eb == 0) ? 1 : eb;
    emin = (ka < kb) ? ka : kb;
    xa = (ea == 0) ? '0 : (320'(fa | (64'd1 << mw)) << (ka - emin));
    xb = (eb == 0) ? '0 : (320'(fb | (64'd1 << mw)) << (kb - emin));
    if (sa == sb) begin
      mag = xa + xb; sg = sa;
    end else if (xa > xb) begin
      mag = xa - xb; sg = sa;
    end else if (xb > xa) begin
      mag = xb - xa; sg = sb;
    end else begin
      return {2'b01, 64'd0};
    end
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    if (p > mw) begin
      sh   = p - mw;
      q    = mag >> sh;
      rem  = mag & ((320'd1 << sh) - 320'd1);
      half = 320'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 320'd1;
      if (q[mw+1]) begin
        q = q >> 1;
        p = p + 1;
      end
    end else begin
      q = mag << (mw - p);
    end
    e = p - mw + emin;
    if (e >= int'(emx)) return {2'b10, pack(ew, mw, sg, emx, 64'd0)};
    if (e <= 0) return {2'b01, pack(ew, mw, sg, 64'd0, 64'd0)};
    return {2'b00, pack(ew, mw, sg, 64'(e), q[63:0] & mmask)};
  endfunction

  function automatic logic [31:0] rnd32(logic [31:0] near_v);
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) r[30:23] = 8'($urandom_range(100, 150));
    else if (k == 4) r = near_v ^ 32'($urandom_range(0, 7));
    else if (k == 5) r[30:23] = near_v[30:23];
    else if (k == 6) r[30:23] = 8'($urandom_range(0, 3));
    else if (k == 7) r[30:23] = 8'($urandom_range(250, 255));
    return r;
  endfunction

  function automatic logic [15:0] rnd16(logic [15:0] near_v);
    logic [15:0] r;
    int k;
    r = 16'($urandom);
    k = $urandom_range(0, 9);
    if (k < 5) r[14:10] = 5'($urandom_range(10, 20));
    else if (k == 5) r = near_v ^ 16'($urandom_range(0, 7));
    else if (k == 6) r[14:10] = near_v[14:10];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (vld && rdy && auto_exp)
        q32.push_back(model(8, 23, 64'(a), 64'(b), sub));
      if (vo) begin
        if (q32.size() == 0) chk("spurious_vld", 66'(vo), 66'(0));
        else begin
          chk("result32", {st, 64'(ans)}, q32[0]);
          if (rin) void'(q32.pop_front());
        end
        if (!rin) chk("rdy_o_stall", 66'(rdy), 66'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hvld && hrdy && hauto)
        qh.push_back(model(5, 10, 64'(ha), 64'(hb), hsub));
      if (hvo) begin
        if (qh.size() == 0) chk("spurious_hvld", 66'(hvo), 66'(0));
        else begin
          chk("result16", {hst, 64'(hans)}, qh[0]);
          if (hrin) void'(qh.pop_front());
        end
      end
    end
  end

  task automatic send32(input logic [31:0] av, input logic [31:0] bv,
                        input logic sv);
    int t = 0;
    a = av; b = bv; sub = sv; vld = 1'b1;
    @(negedge clk);
    while (!rdy && t < 20) begin
      t++;
      @(negedge clk);
    end
    if (!rdy) chk("send_timeout", 66'(rdy), 66'(1));
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic send16(input logic [15:0] av, input logic [15:0] bv,
                        input logic sv);
    ha = av; hb = bv; hsub = sv; hvld = 1'b1;
    @(negedge clk);
    chk("h_rdy", 66'(hrdy), 66'(1));
    @(posedge clk); #1;
    hvld = 1'b0;
  endtask

  task automatic k32(input logic [31:0] av, input logic [31:0] bv,
                     input logic sv, input logic [31:0] ev,
                     input logic [1:0] es);
    q32.push_back({es, 64'(ev)});
    send32(av, bv, sv);
  endtask

  task automatic drain32();
    int t = 0;
    while ((q32.size() != 0 || vo) && t < 60) begin
      t++;
      @(negedge clk);
    end
    chk("drain32", 66'(q32.size()), 66'(0));
    @(posedge clk); #1;
  endtask

  task automatic drain16();
    int t = 0;
    while ((qh.size() != 0 || hvo) && t < 60) begin
      t++;
      @(negedge clk);
    end
    chk("drain16", 66'(qh.size()), 66'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_random32(int n);
    int sent = 0;
    int cyc = 0;
    logic acc;
    auto_exp = 1'b1;
    while ((sent < n || vld) && cyc < 40 * n) begin
      cyc++;
      @(negedge clk);
      acc = vld && rdy;
      @(posedge clk); #1;
      if (!vld || acc) begin
        if (sent < n && $urandom_range(0, 3) != 0) begin
          a   = rnd32(b);
          b   = rnd32(a);
          sub = 1'($urandom_range(0, 1));
          vld = 1'b1;
          sent++;
        end else begin
          vld = 1'b0;
        end
      end
      rin = ($urandom_range(0, 9) < 7);
    end
    if (sent < n || vld) chk("random_timeout", 66'(sent), 66'(n));
    vld = 1'b0;
    rin = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; vld = 1'b0; a = '0; b = '0; sub = 1'b0; rin = 1'b1;
    hvld = 1'b0; ha = '0; hb = '0; hsub = 1'b0; hrin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 66'(vo), 66'(0));
    chk("rst_ans", 66'(ans), 66'(0));
    chk("rst_status", 66'(st), 66'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 66'(rdy), 66'(1));
    @(posedge clk); #1;

    k32(32'h3F600000, 32'h400CCCCD, 1'b0, 32'h4044CCCD, 2'b00);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!vo && cnt < 10);
    chk("latency", 66'(cnt), 66'(3));
    drain32();

    k32(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b01);
    k32(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2'b01);
    k32(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b11);
    k32(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b10);
    k32(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11);
    k32(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00);
    k32(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 2'b00);
    k32(32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 2'b10);
    k32(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 2'b01);
    drain32();

    auto_exp = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send32(rnd32(a), rnd32(b), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 rin = 1'b0;
        repeat (4) @(posedge clk);
        #1 rin = 1'b1;
      end
    join
    drain32();

    run_random32(400);
    drain32();

    send32(32'h3F800000, 32'h40000000, 1'b0);
    send32(32'h40400000, 32'h3F800000, 1'b1);
    #1 rst = 1'b1;
    #1 chk("rst_mid_vld", 66'(vo), 66'(0));
    chk("rst_mid_status", 66'(st), 66'(1));
    q32.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_vld", 66'(vo), 66'(0));
    end
    @(posedge clk); #1;
    auto_exp = 1'b0;

    qh.push_back({2'b01, 64'h4226} ^ {2'b01, 64'h0});
    void'(qh.pop_back());
    qh.push_back({2'b00, 64'h4226});
    send16(16'h3B00, 16'h4066, 1'b0);
    drain16();
    hauto = 1'b1;
    for (int i = 0; i < 200; i++)
      send16(rnd16(ha), rnd16(hb), 1'($urandom_range(0, 1)));
    drain16();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor.
- Successor to the fixed 32-bit pipelined summator. Adds:
  - configurable exponent and mantissa widths,
  - an add/sub operation select,
  - round-to-nearest-even,
  - a valid/ready handshake with backpressure on both sides.
- Sits in the FPU datapath between operand issue logic and result writeback.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored mantissa field width (hidden bit implicit).
- W, EXP_W+MAN_W+1, total operand width (derived, not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- a_i  in  W  operand A, {sign, exp, man}.
- b_i  in  W  operand B.
- sub_i  in  1  0 = A+B, 1 = A-B (B sign inverted at stage 1).
- vld_i  in  1  input operands valid.
- rdy_o  out  1  block accepts input this cycle.
- answer_o  out  W  result.
- num_status_o  out  2  result class: 00 normal, 01 zero, 10 infinity, 11 NaN.
- vld_o  out  1  answer_o / num_status_o valid.
- rdy_i  in  1  downstream accepts result.

Behaviour:
- Reset (async assert, sync release to rising edge):
  - all stage-valid flags cleared;
  - vld_o=0, answer_o=0, num_status_o=2'b01;
  - rdy_o=1 after reset deasserts.
- Pipeline: 3 register stages. Input transfer at cycle N (vld_i & rdy_o) → vld_o high at cycle N+3, absent stalls.
- Stall rule:
  - global enable en = !(vld_o & !rdy_i); rdy_o = en.
  - When en=0, every stage holds its data and valid.
  - When en=1, each stage loads from its predecessor; empty stages (valid=0) propagate bubbles.
  - Throughput is 1 result/cycle when rdy_i stays high.
- Output hold: while vld_o & !rdy_i, answer_o and num_status_o are stable. No result is ever dropped or duplicated.
- Stage 1 (unpack/align):
  - Apply sub_i to B's sign.
  - Classify each operand: zero, denormal (exp=0 with man≠0, flushed to signed zero), inf, NaN.
  - Swap so the larger magnitude is first.
  - Right-shift the smaller mantissa (hidden bit restored) by the exponent difference. Keep guard, round and sticky bits. A shift ≥ MAN_W+3 leaves only sticky.
- Stage 2 (add):
  - Same effective signs → add; else subtract smaller from larger.
  - Result sign = sign of the larger magnitude.
  - Exact cancellation gives +0.
- Stage 3 (normalise/round/pack):
  - Carry-out → right shift by 1 and exp+1, sticky accumulated.
  - Otherwise left-normalise via leading-zero count.
  - Round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalises.
- Boundary cases:
  - Exp ≥ 2^EXP_W-1 after normalisation → ±inf, status 10.
  - Exp ≤ 0 (underflow) → signed zero, status 01. No denormal outputs.
  - Any NaN input, or inf + (−inf) → canonical quiet NaN {0, all-ones exp, 1 followed by zeros}, status 11.
  - inf ± finite → that inf.
  - zero ± zero → +0, except (−0)+(−0) = −0.
- Reset mid-operation: all in-flight results are discarded; no vld_o pulse after reset release until a new accepted input has traversed the pipeline.
- Simultaneous stall and input: when en=0, vld_i is ignored and the upstream source must hold its operands.

Test Plan:
- Basic add: sub_i=0, a=0x3F600000 (0.875), b=0x400CCCCD (2.2) → 3 cycles later vld_o=1, answer_o=0x4044CCCD (3.075), status 00.
- Cancellation and sign handling:
  - sub_i=1, a=b=0x3F800000 → 0x00000000, status 01;
  - a=b=0x80000000, sub_i=0 → 0x80000000, status 01.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, status 11;
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, status 10;
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000, status 11.
- Rounding ties to even:
  - 0x3F800000 + 0x33800000 (2^-24) → 0x3F800000;
  - 0x3F800001 + 0x33800000 → 0x3F800002.
- Backpressure: stream 6 back-to-back valid inputs with rdy_i held low for cycles 4–7.
  - rdy_o goes low while vld_o & !rdy_i.
  - answer_o is stable across the stall.
  - All 6 results emerge in order, none lost or duplicated.
- Reset mid-flight plus parametrisation:
  - Assert rst_i with 2 results in flight → vld_o=0 immediately and no stale output afterwards.
  - Rerun the basic-add check with EXP_W=5, MAN_W=10 (half): 0x3B00 + 0x4066 → 0x4226, status 00.
